dual_cam_capture_sched: RTL and testbench

Frame-level scheduler that shares the single DDR write-DMA channel between camera 1 and camera 2. Sits between the camera register bank (init-done, trigger and continuous-mode bits), the two camera vsync pulses, and the write-DMA command interface. Per camera it manages a ring of NUM_BUF frame buffers and never writes into the buffer the display is reading. It also keeps the drop and error counters that the APB status registers expose.

---
 rtl/dual_cam_capture_sched_if.sv | 20 ++
 rtl/dual_cam_capture_sched.sv | 215 +++++++++++++++++++++
 tb/tb_dual_cam_capture_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_cam_capture_sched_if.sv
// Write-DMA command channel shared by both cameras: one-shot start/abort
// commands with target selection, and done/error completion pulses.
interface dual_cam_capture_sched_if;
  logic       dma_start;
  logic       dma_cam_sel;
  logic [1:0] dma_buf_idx;
  logic       dma_abort;
  logic       dma_done;
  logic       dma_error;

  modport master (
    output dma_start, dma_cam_sel, dma_buf_idx, dma_abort,
    input  dma_done, dma_error
  );

  modport slave (
    input  dma_start, dma_cam_sel, dma_buf_idx, dma_abort,
    output dma_done, dma_error
  );
endinterface

// File: rtl/dual_cam_capture_sched.sv
// Frame scheduler sharing one write-DMA channel between two cameras, rotating
// each camera through a buffer ring that skips the buffer under display.
module dual_cam_capture_sched #(
  parameter int unsigned NUM_BUF = 3,
  parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cam1_dma_init_done,
  input  logic                     cam1_continuous,
  input  logic                     cam1_trigger_capture_frame,
  input  logic                     cam1_vsync,
  input  logic [1:0]               cam1_disp_rd_idx,
  input  logic                     cam2_dma_init_done,
  input  logic                     cam2_continuous,
  input  logic                     cam2_trigger_capture_frame,
  input  logic                     cam2_vsync,
  input  logic [1:0]               cam2_disp_rd_idx,
  dual_cam_capture_sched_if.master dma,
  output logic                     cam1_frame_done,
  output logic [1:0]               cam1_rdy_idx,
  output logic                     cam1_rdy_valid,
  output logic [15:0]              cam1_drop_cnt,
  output logic                     cam2_frame_done,
  output logic [1:0]               cam2_rdy_idx,
  output logic                     cam2_rdy_valid,
  output logic [15:0]              cam2_drop_cnt,
  output logic [15:0]              err_cnt,
  output logic                     busy
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [IDX_W-1:0]   buf_q, buf_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               grant;
  logic               gcam;
  logic               err_inc;

  logic               last_q;
  logic               dma_start_q;
  logic               abort_q;
  logic               busy_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic [1:0]         init_c, cont_c, trig_c, vsync_c;
  logic [IDX_W-1:0]   disp_c [2];
  logic [1:0]         elig, req, active;
  logic [IDX_W-1:0]   wr_nxt [2];

  logic [1:0]         pend_q, armed_q, trig_q, frame_done_q, rdy_valid_q;
  logic [IDX_W-1:0]   wr_idx_q  [2];
  logic [IDX_W-1:0]   rdy_idx_q [2];
  logic [CNT_W-1:0]   drop_q    [2];

  function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  assign init_c    = {cam2_dma_init_done, cam1_dma_init_done};
  assign cont_c    = {cam2_continuous, cam1_continuous};
  assign trig_c    = {cam2_trigger_capture_frame, cam1_trigger_capture_frame};
  assign vsync_c   = {cam2_vsync, cam1_vsync};
  assign disp_c[0] = cam1_disp_rd_idx;
  assign disp_c[1] = cam2_disp_rd_idx;

  // Per-camera eligibility, request and next write buffer (skips displayed one)
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]   = enable & init_c[i] & (cont_c[i] | armed_q[i]);
      req[i]    = pend_q[i] & elig[i];
      wr_nxt[i] = (step(wr_idx_q[i]) == disp_c[i]) ? step(step(wr_idx_q[i]))
                                                   : step(wr_idx_q[i]);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      buf_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
    end
  end

  // FSM next state; error beats a timeout, and a timeout beats a late done
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    buf_d   = buf_q;
    tmo_d   = tmo_q;
    grant   = 1'b0;
    gcam    = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (req[0] | req[1]) begin
          grant   = 1'b1;
          gcam    = (req[0] & req[1]) ? ~last_q : req[1];
          sel_d   = gcam;
          buf_d   = wr_idx_q[gcam];
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (dma.dma_error) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TIMEOUT - TMO_W'(1)) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (dma.dma_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A camera owns the channel from its grant cycle until the FSM is idle again
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      active[i] = ((state_q != IDLE) && (sel_q == 1'(i))) ||
                  (grant && (gcam == 1'(i)));
    end
  end

  // Registered outputs, counters and per-camera bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_start_q <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
      last_q      <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        pend_q[i]       <= 1'b0;
        armed_q[i]      <= 1'b0;
        trig_q[i]       <= 1'b0;
        frame_done_q[i] <= 1'b0;
        rdy_valid_q[i]  <= 1'b0;
        wr_idx_q[i]     <= '0;
        rdy_idx_q[i]    <= '0;
        drop_q[i]       <= '0;
      end
    end else begin
      dma_start_q <= (state_d == START);
      abort_q     <= (state_d == BUSY) && (tmo_d == TIMEOUT - TMO_W'(1));
      busy_q      <= (state_d != IDLE);
      if (err_inc && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (state_q == DONE) last_q <= sel_q;

      for (int i = 0; i < 2; i++) begin
        trig_q[i] <= trig_c[i];

        if (!elig[i])                           pend_q[i] <= 1'b0;
        else if (grant && (gcam == 1'(i)))      pend_q[i] <= 1'b0;
        else if (vsync_c[i] && !active[i])      pend_q[i] <= 1'b1;

        if (elig[i] && vsync_c[i] && (active[i] || pend_q[i]) && (drop_q[i] != CNT_MAX))
          drop_q[i] <= drop_q[i] + CNT_W'(1);

        if (!init_c[i])                          armed_q[i] <= 1'b0;
        else if (trig_c[i] && !trig_q[i])        armed_q[i] <= 1'b1;
        else if ((state_q == DONE) && (sel_q == 1'(i)) && !cont_c[i])
                                                 armed_q[i] <= 1'b0;

        frame_done_q[i] <= (state_d == DONE) && (sel_q == 1'(i));
        if ((state_d == DONE) && (sel_q == 1'(i))) begin
          rdy_idx_q[i]   <= buf_q;
          rdy_valid_q[i] <= 1'b1;
        end
        if ((state_q == DONE) && (sel_q == 1'(i))) wr_idx_q[i] <= wr_nxt[i];
      end
    end
  end

  assign dma.dma_start   = dma_start_q;
  assign dma.dma_cam_sel = sel_q;
  assign dma.dma_buf_idx = buf_q;
  assign dma.dma_abort   = abort_q;

  assign cam1_frame_done = frame_done_q[0];
  assign cam1_rdy_idx    = rdy_idx_q[0];
  assign cam1_rdy_valid  = rdy_valid_q[0];
  assign cam1_drop_cnt   = drop_q[0];
  assign cam2_frame_done = frame_done_q[1];
  assign cam2_rdy_idx    = rdy_idx_q[1];
  assign cam2_rdy_valid  = rdy_valid_q[1];
  assign cam2_drop_cnt   = drop_q[1];
  assign err_cnt         = err_cnt_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_dual_cam_capture_sched.sv
// Directed bench for dual_cam_capture_sched: a scripted DMA responder logs
// every grant, and the main sequence compares against hand-derived values.
module tb_dual_cam_capture_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic        cam1_dma_init_done, cam1_continuous, cam1_trigger_capture_frame, cam1_vsync;
  logic        cam2_dma_init_done, cam2_continuous, cam2_trigger_capture_frame, cam2_vsync;
  logic [1:0]  cam1_disp_rd_idx, cam2_disp_rd_idx;
  logic        cam1_frame_done, cam1_rdy_valid, cam2_frame_done, cam2_rdy_valid;
  logic [1:0]  cam1_rdy_idx, cam2_rdy_idx;
  logic [15:0] cam1_drop_cnt, cam2_drop_cnt, err_cnt;
  logic        busy;

  dual_cam_capture_sched_if dif();

  dual_cam_capture_sched #(.NUM_BUF(3), .TIMEOUT(24'd16)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .enable                     (enable),
    .cam1_dma_init_done         (cam1_dma_init_done),
    .cam1_continuous            (cam1_continuous),
    .cam1_trigger_capture_frame (cam1_trigger_capture_frame),
    .cam1_vsync                 (cam1_vsync),
    .cam1_disp_rd_idx           (cam1_disp_rd_idx),
    .cam2_dma_init_done         (cam2_dma_init_done),
    .cam2_continuous            (cam2_continuous),
    .cam2_trigger_capture_frame (cam2_trigger_capture_frame),
    .cam2_vsync                 (cam2_vsync),
    .cam2_disp_rd_idx           (cam2_disp_rd_idx),
    .dma                        (dif),
    .cam1_frame_done            (cam1_frame_done),
    .cam1_rdy_idx               (cam1_rdy_idx),
    .cam1_rdy_valid             (cam1_rdy_valid),
    .cam1_drop_cnt              (cam1_drop_cnt),
    .cam2_frame_done            (cam2_frame_done),
    .cam2_rdy_idx               (cam2_rdy_idx),
    .cam2_rdy_valid             (cam2_rdy_valid),
    .cam2_drop_cnt              (cam2_drop_cnt),
    .err_cnt                    (err_cnt),
    .busy                       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // responder: mode 0 = done, 1 = error, 2 = silent; rsp_dly cycles after start
  int rsp_mode = 0;
  int rsp_dly = 10;
  int rsp_cnt = -1;
  int n_grant = 0;
  int n_abort = 0;
  int abort_cyc = 0;
  int fd1 = 0;
  int fd2 = 0;
  int g_cam [64];
  int g_buf [64];
  int g_cyc [64];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vs_pulse(input logic v1, input logic v2);
    cam1_vsync = v1;
    cam2_vsync = v2;
    tick(1);
    cam1_vsync = 1'b0;
    cam2_vsync = 1'b0;
  endtask

  initial begin
    dif.dma_done  = 1'b0;
    dif.dma_error = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dif.dma_done  = 1'b0;
      dif.dma_error = 1'b0;
      if (cam1_frame_done) fd1++;
      if (cam2_frame_done) fd2++;
      if (dif.dma_abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
      if (dif.dma_start) begin
        if (n_grant < 64) begin
          g_cam[n_grant] = int'(dif.dma_cam_sel);
          g_buf[n_grant] = int'(dif.dma_buf_idx);
          g_cyc[n_grant] = cyc;
        end
        n_grant++;
        rsp_cnt = (rsp_mode == 2) ? -1 : rsp_dly;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          if (rsp_mode == 1) dif.dma_error = 1'b1;
          else               dif.dma_done  = 1'b1;
          rsp_cnt = -1;
        end
      end
    end
  end

  int exp_buf1 [4] = '{0, 1, 0, 1};
  int exp_rr_cam [4] = '{1, 0, 1, 0};
  int exp_rr_buf [4] = '{0, 0, 1, 1};

  initial begin
    int base, vs, fd_prev, ab_prev;
    rst = 1'b1;
    enable = 1'b0;
    cam1_dma_init_done = 1'b0; cam1_continuous = 1'b0;
    cam1_trigger_capture_frame = 1'b0; cam1_vsync = 1'b0;
    cam2_dma_init_done = 1'b0; cam2_continuous = 1'b0;
    cam2_trigger_capture_frame = 1'b0; cam2_vsync = 1'b0;
    cam1_disp_rd_idx = 2'd2;
    cam2_disp_rd_idx = 2'd2;
    tick(3);
    rst = 1'b0;
    tick(1);

    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_start", int'(dif.dma_start), 0);
    check_eq("rst_abort", int'(dif.dma_abort), 0);
    check_eq("rst_sel", int'(dif.dma_cam_sel), 0);
    check_eq("rst_buf", int'(dif.dma_buf_idx), 0);
    check_eq("rst_err", int'(err_cnt), 0);
    check_eq("rst_rdy_valid1", int'(cam1_rdy_valid), 0);
    check_eq("rst_drop2", int'(cam2_drop_cnt), 0);

    // single camera continuous; buffer 2 is on display so the ring is 0,1,0,1
    enable = 1'b1;
    cam1_dma_init_done = 1'b1;
    cam1_continuous = 1'b1;
    tick(2);
    for (int f = 0; f < 4; f++) begin
      base = n_grant;
      vs = cyc;
      vs_pulse(1'b1, 1'b0);
      tick(48);
      check_eq("c1_ngrant", n_grant - base, 1);
      check_eq("c1_cam", g_cam[base], 0);
      check_eq("c1_buf", g_buf[base], exp_buf1[f]);
      check_eq("c1_latency", g_cyc[base] - vs, 2);
      check_eq("c1_rdy_idx", int'(cam1_rdy_idx), exp_buf1[f]);
      check_eq("c1_rdy_valid", int'(cam1_rdy_valid), 1);
    end
    check_eq("c1_drop", int'(cam1_drop_cnt), 0);
    check_eq("c1_fdone", fd1, 4);

    // simultaneous vsyncs; last winner was cam1, so cam2 takes the first tie
    cam2_dma_init_done = 1'b1;
    cam2_continuous = 1'b1;
    tick(2);
    base = n_grant;
    for (int r = 0; r < 2; r++) begin
      vs_pulse(1'b1, 1'b1);
      tick(48);
    end
    check_eq("rr_ngrant", n_grant - base, 4);
    for (int j = 0; j < 4; j++) begin
      check_eq("rr_cam", g_cam[base + j], exp_rr_cam[j]);
      check_eq("rr_buf", g_buf[base + j], exp_rr_buf[j]);
    end
    check_eq("rr_gap", g_cyc[base + 1] - g_cyc[base], 13);
    check_eq("rr_drop1", int'(cam1_drop_cnt), 0);
    check_eq("rr_drop2", int'(cam2_drop_cnt), 0);
    check_eq("rr_fdone2", fd2, 2);

    // single-shot: unarmed vsyncs are ignored, one trigger buys one frame
    cam2_dma_init_done = 1'b0;
    cam1_continuous = 1'b0;
    tick(2);
    base = n_grant;
    for (int k = 0; k < 3; k++) begin
      vs_pulse(1'b1, 1'b0);
      tick(29);
    end
    check_eq("ss_noarm_grant", n_grant - base, 0);
    check_eq("ss_noarm_drop", int'(cam1_drop_cnt), 0);
    fd_prev = fd1;
    cam1_trigger_capture_frame = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      vs_pulse(1'b1, 1'b0);
      tick(29);
    end
    check_eq("ss_grant", n_grant - base, 1);
    check_eq("ss_cam", g_cam[base], 0);
    check_eq("ss_buf", g_buf[base], 0);
    check_eq("ss_fdone", fd1 - fd_prev, 1);
    check_eq("ss_drop", int'(cam1_drop_cnt), 0);
    cam1_trigger_capture_frame = 1'b0;

    // overrun: two cam2 vsyncs during one cam1 transfer
    cam1_continuous = 1'b1;
    cam2_dma_init_done = 1'b1;
    cam2_continuous = 1'b1;
    tick(2);
    base = n_grant;
    vs_pulse(1'b1, 1'b0);
    tick(3);
    vs_pulse(1'b0, 1'b1);
    tick(3);
    vs_pulse(1'b0, 1'b1);
    tick(50);
    check_eq("ov_ngrant", n_grant - base, 2);
    check_eq("ov_cam0", g_cam[base], 0);
    check_eq("ov_buf0", g_buf[base], 1);
    check_eq("ov_cam1", g_cam[base + 1], 1);
    check_eq("ov_buf1", g_buf[base + 1], 0);
    check_eq("ov_gap", g_cyc[base + 1] - g_cyc[base], 13);
    check_eq("ov_drop2", int'(cam2_drop_cnt), 1);
    check_eq("ov_drop1", int'(cam1_drop_cnt), 0);

    // transfer error: counted, no buffer or ready update
    cam2_dma_init_done = 1'b0;
    rsp_mode = 1;
    tick(2);
    fd_prev = fd1;
    base = n_grant;
    vs_pulse(1'b1, 1'b0);
    tick(30);
    check_eq("er_ngrant", n_grant - base, 1);
    check_eq("er_buf", g_buf[base], 0);
    check_eq("er_cnt", int'(err_cnt), 1);
    check_eq("er_rdy_idx", int'(cam1_rdy_idx), 1);
    check_eq("er_fdone", fd1 - fd_prev, 0);
    check_eq("er_abort", n_abort, 0);
    check_eq("er_busy", int'(busy), 0);

    // timeout: abort lands 16 cycles after start
    rsp_mode = 2;
    base = n_grant;
    vs_pulse(1'b1, 1'b0);
    tick(30);
    check_eq("to_ngrant", n_grant - base, 1);
    check_eq("to_buf", g_buf[base], 0);
    check_eq("to_abort", n_abort, 1);
    check_eq("to_abort_time", abort_cyc - g_cyc[base], 16);
    check_eq("to_err", int'(err_cnt), 2);
    check_eq("to_busy", int'(busy), 0);
    check_eq("to_rdy_idx", int'(cam1_rdy_idx), 1);

    // reset in the middle of a transfer
    rsp_mode = 0;
    base = n_grant;
    vs_pulse(1'b1, 1'b0);
    tick(30);
    check_eq("rs_pre_buf", g_buf[base], 0);
    rsp_mode = 2;
    base = n_grant;
    vs_pulse(1'b1, 1'b0);
    tick(7);
    check_eq("rs_pre_busy", int'(busy), 1);
    check_eq("rs_pre_grant_buf", g_buf[base], 1);
    ab_prev = n_abort;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("rs_busy", int'(busy), 0);
    check_eq("rs_err", int'(err_cnt), 0);
    check_eq("rs_drop2", int'(cam2_drop_cnt), 0);
    check_eq("rs_rdy_valid1", int'(cam1_rdy_valid), 0);
    check_eq("rs_rdy_idx1", int'(cam1_rdy_idx), 0);
    check_eq("rs_start", int'(dif.dma_start), 0);
    tick(30);
    check_eq("rs_no_abort", n_abort - ab_prev, 0);
    rsp_mode = 0;
    base = n_grant;
    vs = cyc;
    vs_pulse(1'b1, 1'b0);
    tick(30);
    check_eq("rs_ngrant", n_grant - base, 1);
    check_eq("rs_buf", g_buf[base], 0);
    check_eq("rs_latency", g_cyc[base] - vs, 2);
    check_eq("rs_rdy_valid", int'(cam1_rdy_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
